// File: rtl/pixel_addr_pkg.sv
// Shared types and default sizes for the pixel address generator.
package pixel_addr_pkg;

    localparam int DEF_COORD_W   = 10;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_PIXELBITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_addr_gen_xy_counter.sv
// x/y raster counter: x runs fastest, wraps at width-1 and bumps y.
// o_last flags the final pixel of the frame.
module xy_counter
    import pixel_addr_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_adv,
    input  logic [COORD_W-1:0] i_width,
    input  logic [COORD_W-1:0] i_height,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_x_last,
    output logic               o_last
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_x_last = (r_x == i_width - COORD_W'(1));
    assign o_last   = o_x_last && (r_y == i_height - COORD_W'(1));

    // Step the coordinate pair on each accepted beat; clear on reset or new frame.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (o_x_last) begin
                r_x <= '0;
                r_y <= o_last ? '0 : r_y + COORD_W'(1);
            end else begin
                r_x <= r_x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_addr_gen.sv
// Raster-scan pixel address generator. Emits (x, y, byte address) beats over
// a valid/ready handshake; the address is built with additions only.
module pixel_addr_gen
    import pixel_addr_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PIXELBITS = DEF_PIXELBITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    stride,
    input  logic [COORD_W-1:0]   width,
    input  logic [COORD_W-1:0]   height,
    input  logic [PIXELBITS-1:0] pixel_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 busy,
    output logic                 done
);

    state_t              r_state;
    logic                r_valid;
    logic                r_done;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_stride;
    logic [ADDR_W-1:0]   r_step;
    logic [COORD_W-1:0]  r_width;
    logic [COORD_W-1:0]  r_height;

    logic                w_load;
    logic                w_xfer;
    logic                w_adv;
    logic                w_x_last;
    logic                w_last;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_xfer = r_valid && out_ready;
    assign w_adv  = (r_state == ST_RUN) && w_xfer && !abort;

    xy_counter #(
        .COORD_W (COORD_W)
    ) u_xy (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_load),
        .i_adv    (w_adv),
        .i_width  (r_width),
        .i_height (r_height),
        .o_x      (out_x),
        .o_y      (out_y),
        .o_x_last (w_x_last),
        .o_last   (w_last)
    );

    assign out_valid = r_valid;
    assign out_addr  = r_addr;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

    // Scan control FSM plus the incremental row/pixel address accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_stride   <= '0;
            r_step     <= '0;
            r_width    <= '0;
            r_height   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_stride   <= stride;
                        r_step     <= ADDR_W'(pixel_size >> 3);
                        r_width    <= width;
                        r_height   <= height;
                        r_row_base <= base_addr;
                        r_addr     <= base_addr;
                        if (width != '0 && height != '0) begin
                            r_state <= ST_RUN;
                            r_valid <= 1'b1;
                        end else begin
                            // Empty frame: straight to the completion pulse.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_x_last) begin
                            r_row_base <= r_row_base + r_stride;
                            r_addr     <= r_row_base + r_stride;
                        end else begin
                            r_addr <= r_addr + r_step;
                        end
                    end
                end
                default: begin
                    // DONE (or abort in DONE): one-cycle pulse, back to idle.
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Self-checking bench for pixel_addr_gen: directed frames with literal
// expectations plus randomized traffic against a frame-list reference model.
`timescale 1ns/1ps
module tb_pixel_addr_gen;

    localparam int CW = 10;
    localparam int AW = 32;
    localparam int PB = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [CW-1:0] width;
    logic [CW-1:0] height;
    logic [PB-1:0] pixel_size;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    pixel_addr_gen #(
        .COORD_W   (CW),
        .ADDR_W    (AW),
        .PIXELBITS (PB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .stride     (stride),
        .width      (width),
        .height     (height),
        .pixel_size (pixel_size),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [AW-1:0] a;
    } beat_t;

    beat_t q[$];
    logic  m_valid = 1'b0;
    logic  m_busy  = 1'b0;
    logic  m_done  = 1'b0;
    logic  m_zero  = 1'b1;

    // Whole frame as a list of beats, from the closed-form address rule.
    task automatic build_frame();
        logic [AW-1:0] step;
        beat_t b;
        q.delete();
        step = AW'(pixel_size >> 3);
        for (int y = 0; y < int'(height); y++) begin
            for (int x = 0; x < int'(width); x++) begin
                b.x = CW'(x);
                b.y = CW'(y);
                b.a = base_addr + AW'(y) * stride + AW'(x) * step;
                q.push_back(b);
            end
        end
    endtask

    // Compare on every falling edge, then predict the state after the next rising edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("valid", 64'(out_valid), 64'(m_valid));
            chk("busy",  64'(busy),      64'(m_busy));
            chk("done",  64'(done),      64'(m_done));
            if (m_valid && q.size() > 0) begin
                chk("x",    64'(out_x),    64'(q[0].x));
                chk("y",    64'(out_y),    64'(q[0].y));
                chk("addr", 64'(out_addr), 64'(q[0].a));
            end
            if (m_zero) begin
                chk("rst_x",    64'(out_x),    64'(0));
                chk("rst_y",    64'(out_y),    64'(0));
                chk("rst_addr", 64'(out_addr), 64'(0));
            end
            if (rst) begin
                m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b1;
                q.delete();
            end else if (!m_busy) begin
                if (start) begin
                    m_zero = 1'b0;
                    build_frame();
                    m_busy = 1'b1;
                    if (width == '0 || height == '0) begin
                        m_done  = 1'b1;
                        m_valid = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                    end
                end
            end else if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else begin
                if (abort) begin
                    m_valid = 1'b0; m_busy = 1'b0;
                    q.delete();
                end else if (out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_valid = 1'b0;
                        m_done  = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input int w, input int h, input int ps);
        base_addr  = b;
        stride     = s;
        width      = CW'(w);
        height     = CW'(h);
        pixel_size = PB'(ps);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Scramble the frame inputs: the scan must use the latched copies.
        base_addr  = $urandom;
        stride     = $urandom;
        width      = CW'($urandom_range(0, 7));
        height     = CW'($urandom_range(0, 7));
        pixel_size = PB'($urandom_range(0, 63));
    endtask

    task automatic chk_beat(input string nm, input int x, input int y, input logic [AW-1:0] a);
        chk({nm, "_valid"}, 64'(out_valid), 64'(1));
        chk({nm, "_x"},     64'(out_x),     64'(x));
        chk({nm, "_y"},     64'(out_y),     64'(y));
        chk({nm, "_addr"},  64'(out_addr),  64'(a));
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n = 0;
        while (busy && n < 200) begin
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; stride = '0; width = '0; height = '0; pixel_size = '0;
        tick(); tick();
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_busy",  64'(busy),      64'(0));
        chk("reset_done",  64'(done),      64'(0));
        chk("reset_addr",  64'(out_addr),  64'(0));
        rst = 1'b0;
        tick();

        // 2x2 frame, ready always high.
        start_frame(32'h3E8, 32'h280, 2, 2, 8);
        chk_beat("f1b0", 0, 0, 32'h3E8); tick();
        chk_beat("f1b1", 1, 0, 32'h3E9); tick();
        chk_beat("f1b2", 0, 1, 32'h668); tick();
        chk_beat("f1b3", 1, 1, 32'h669); tick();
        chk("f1_done",  64'(done),      64'(1));
        chk("f1_valid", 64'(out_valid), 64'(0));
        tick();
        chk("f1_done_off", 64'(done), 64'(0));
        chk("f1_idle",     64'(busy), 64'(0));
        tick();

        // Same frame with backpressure on the second beat.
        start_frame(32'h3E8, 32'h280, 2, 2, 8);
        chk_beat("f2b0", 0, 0, 32'h3E8); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat("f2hold", 1, 0, 32'h3E9);
            tick();
        end
        out_ready = 1'b1;
        chk_beat("f2b1", 1, 0, 32'h3E9); tick();
        chk_beat("f2b2", 0, 1, 32'h668); tick();
        chk_beat("f2b3", 1, 1, 32'h669); tick();
        chk("f2_done", 64'(done), 64'(1));
        tick();

        // Empty frame.
        start_frame(32'h100, 32'h10, 0, 5, 8);
        chk("f3_done",  64'(done),      64'(1));
        chk("f3_busy",  64'(busy),      64'(1));
        chk("f3_valid", 64'(out_valid), 64'(0));
        tick();
        chk("f3_done_off", 64'(done), 64'(0));
        chk("f3_busy_off", 64'(busy), 64'(0));
        tick();

        // Address wrap at 2^32.
        start_frame(32'hFFFF_FFFE, 32'h100, 2, 1, 32);
        chk_beat("f4b0", 0, 0, 32'hFFFF_FFFE); tick();
        chk_beat("f4b1", 1, 0, 32'h0000_0002); tick();
        chk("f4_done", 64'(done), 64'(1));
        tick();

        // Abort on the third beat of a 4x4 scan, then restart.
        start_frame(32'h1000, 32'h40, 4, 4, 16);
        chk_beat("f5b0", 0, 0, 32'h1000); tick();
        chk_beat("f5b1", 1, 0, 32'h1002); tick();
        chk_beat("f5b2", 2, 0, 32'h1004);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("f5_abort_valid", 64'(out_valid), 64'(0));
        chk("f5_abort_done",  64'(done),      64'(0));
        chk("f5_abort_busy",  64'(busy),      64'(0));
        tick();
        chk("f5_no_done", 64'(done), 64'(0));
        start_frame(32'h1000, 32'h40, 4, 4, 16);
        chk_beat("f5r0", 0, 0, 32'h1000);
        wait_idle(1'b0);

        // Reset mid-scan together with start, then a full randomized-ready scan.
        start_frame(32'h2000, 32'h80, 4, 4, 8);
        tick(); tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("f6_valid", 64'(out_valid), 64'(0));
        chk("f6_done",  64'(done),      64'(0));
        chk("f6_busy",  64'(busy),      64'(0));
        chk("f6_x",     64'(out_x),     64'(0));
        chk("f6_y",     64'(out_y),     64'(0));
        chk("f6_addr",  64'(out_addr),  64'(0));
        tick();
        start_frame(32'h2000, 32'h80, 3, 2, 24);
        wait_idle(1'b1);

        // Randomized traffic: starts, aborts, resets, backpressure, input churn.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            abort      = ($urandom_range(0, 29) == 0);
            start      = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            base_addr  = $urandom;
            stride     = $urandom;
            width      = CW'($urandom_range(0, 4));
            height     = CW'($urandom_range(0, 4));
            pixel_size = PB'($urandom_range(0, 63));
            tick();
        end
        rst = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b1;
        wait_idle(1'b0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
